pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory over a valid/ready request and response interface.
- Presents each fetched instruction and its PC to the single-cycle datapath.
- When the datapath commits the instruction, the block loads the next PC. Candidates are the datapath-computed PCPlus4 and PCBranch, or a jump target.
- Sits between instruction memory and the datapath adders and sign-extend stage. It is the producer of the PC/Instr those stages consume.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned).
- N, 32, PC, address and instruction width (only 32 is supported).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- PCPlus4  input  N  sequential next PC from datapath
- PCBranch  input  N  branch target from datapath
- PCJump  input  N  jump target from datapath
- PCSrc  input  1  branch taken
- Jump  input  1  jump taken
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  N  fetch address (= PC)
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  instruction word valid
- imem_rsp_data  input  N  instruction word
- PC  output  N  PC of presented instruction
- Instr  output  N  presented instruction
- instr_valid  output  1  Instr/PC valid for datapath
- instr_ready  input  1  datapath commits presented instruction this cycle
- fetch_err  output  1  sticky misaligned-PC error
- instr_count  output  N  committed-instruction counter

Behaviour:
- All state updates on the rising edge of clk. reset_n is sampled synchronously and, while low, overrides every other input.
- Reset values:
  - PC = RESET_PC; Instr = 0; instr_count = 0
  - instr_valid = 0; imem_req_valid = 0; fetch_err = 0
  - state = REQ
- imem_req_addr is combinationally equal to PC.
- The FSM has four states: REQ, WAIT, HOLD, ERR.
- REQ:
  - imem_req_valid = 1.
  - If imem_req_ready = 1 in the same cycle, the request is accepted and the next state is WAIT. Otherwise stay in REQ with address stable.
  - The first request is asserted in the first cycle after reset_n is sampled high.
- WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid = 1, Instr <= imem_rsp_data, instr_valid <= 1, next state HOLD.
  - Zero-wait memory: rsp_valid may arrive in the cycle after acceptance, giving a minimum fetch latency of 2 cycles from request to instr_valid.
- HOLD:
  - instr_valid = 1; Instr and PC are held stable.
  - When instr_ready = 1:
    - instr_count <= instr_count + 1, wrapping from 32'hFFFF_FFFF to 0.
    - instr_valid <= 0.
    - PC <= next PC, selected with priority Jump > PCSrc > PCPlus4: Jump = 1 selects PCJump, else PCSrc = 1 selects PCBranch, else PCPlus4.
    - If the selected next PC has bits [1:0] != 0: PC still loads it, fetch_err <= 1, next state ERR. Otherwise next state REQ.
- ERR:
  - imem_req_valid = 0 and instr_valid = 0.
  - Stays in ERR until reset; fetch_err stays 1.
- imem_rsp_valid is ignored outside WAIT. No extra Instr load occurs, and a stray response must not corrupt Instr.
- Only one request may be outstanding at a time; a new request is never issued before the response is captured.
- PCSrc, Jump and the target inputs are sampled only in the HOLD cycle where instr_ready = 1. They are don't-care otherwise.
- instr_ready while instr_valid = 0 has no effect; the counter and PC do not change.
- Reset mid-operation (any state) returns to REQ with reset values. The instruction memory responder is required to drop any outstanding response on reset.
- Back-to-back throughput: with always-ready memory and rsp one cycle after accept, one instruction commits every 3 cycles (REQ, WAIT, HOLD).

Test Plan:
- Reset and sequential fetch:
  - Stimulus: reset, RESET_PC=0; memory zero-wait returning 32'h2008_0005 then 32'h2009_0003; datapath instr_ready=1 with PCPlus4 = PC+4.
  - Required response: req addr 0, then 4; PC 0 then 4; instr_valid pulses; instr_count=2.
- Memory back-pressure:
  - Stimulus: imem_req_ready held low 3 cycles, then rsp delayed 4 cycles after accept.
  - Required response: req_valid=1 with addr stable for 4 cycles; instr_valid rises exactly one cycle after rsp_valid.
- Branch/jump priority:
  - Stimulus: in HOLD at PC=8, PCPlus4=12, PCBranch=32, PCJump=64. Apply PCSrc=1,Jump=1.
  - Required response: next PC=64. Repeating with PCSrc=1,Jump=0 requires next PC=32.
- Misaligned target:
  - Stimulus: PCBranch=32'h0000_0022, PCSrc=1 at commit.
  - Required response: PC=0x22, fetch_err=1, no further req_valid. The error clears only after reset_n pulses low, with PC=RESET_PC.
- Stray response and datapath stall:
  - Stimulus: rsp_valid=1 with data 32'hDEAD_BEEF while in HOLD, plus instr_ready=0 for 5 cycles.
  - Required response: Instr keeps its original value, PC unchanged, instr_count unchanged.
- Counter wrap:
  - Stimulus: instr_count at 32'hFFFF_FFFF, then one commit.
  - Required response: instr_count = 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch sequencer: requests the word at PC from
// instruction memory, presents it to the datapath and advances PC on commit.
module pc_fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] PCPlus4,
    input  logic [N-1:0] PCBranch,
    input  logic [N-1:0] PCJump,
    input  logic         PCSrc,
    input  logic         Jump,
    output logic         imem_req_valid,
    output logic [N-1:0] imem_req_addr,
    input  logic         imem_req_ready,
    input  logic         imem_rsp_valid,
    input  logic [N-1:0] imem_rsp_data,
    output logic [N-1:0] PC,
    output logic [N-1:0] Instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic         fetch_err,
    output logic [N-1:0] instr_count,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and payload is stable while
    // valid is high and ready is low. Only one memory request is outstanding.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_instr;
    logic [N-1:0] r_instr_count;
    logic         r_req_valid;
    logic         r_instr_valid;
    logic         r_fetch_err;
    logic [N-1:0] w_next_pc;
    logic         w_misaligned;
    logic         w_commit;
    logic         w_capture;

    always_comb begin
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_capture    = 1'b0;
        w_next_pc    = Jump ? PCJump : (PCSrc ? PCBranch : PCPlus4);
        w_misaligned = |w_next_pc[1:0];
        case (r_state)
            ST_REQ: begin
                if (r_req_valid && imem_req_ready) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    w_commit     = 1'b1;
                    w_next_state = w_misaligned ? ST_ERR : ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_ERR;
            end
        endcase
    end

    // Valid flags are registered from the next state so that both are low
    // while reset is held, and the first request appears one cycle after it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_REQ;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_count <= '0;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_req_valid   <= (w_next_state == ST_REQ);
            r_instr_valid <= (w_next_state == ST_HOLD);
            if (w_capture) begin
                r_instr <= imem_rsp_data;
            end
            if (w_commit) begin
                r_pc          <= w_next_pc;
                r_instr_count <= r_instr_count + {{(N-1){1'b0}}, 1'b1};
                if (w_misaligned) begin
                    r_fetch_err <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign PC             = r_pc;
    assign Instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign fetch_err      = r_fetch_err;
    assign instr_count    = r_instr_count;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: acts as instruction memory and
// datapath, predicting PC, Instr, counter and error flag from commit rules.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] PCPlus4;
    logic [31:0] PCBranch;
    logic [31:0] PCJump;
    logic        PCSrc;
    logic        Jump;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;
    logic [31:0] instr_count;
    logic [1:0]  dbg_state;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_count;
    logic        exp_err;

    pc_fetch_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .PCPlus4        (PCPlus4),
        .PCBranch       (PCBranch),
        .PCJump         (PCJump),
        .PCSrc          (PCSrc),
        .Jump           (Jump),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PC             (PC),
        .Instr          (Instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_err      (fetch_err),
        .instr_count    (instr_count),
        .dbg_state      (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives reset for three cycles and checks the reset values while held.
    task automatic do_reset();
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        PCSrc          = 1'b0;
        Jump           = 1'b0;
        PCPlus4        = 32'h0;
        PCBranch       = 32'h0;
        PCJump         = 32'h0;
        repeat (3) @(negedge clk);
        exp_pc    = 32'h0;
        exp_count = 32'h0;
        exp_instr = 32'h0;
        exp_err   = 1'b0;
        tests_run++;
        if (PC !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h expected %h", PC, 32'h0);
        end
        tests_run++;
        if (Instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_instr: got %h expected 0", Instr);
        end
        tests_run++;
        if (instr_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_count: got %h expected 0", instr_count);
        end
        tests_run++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: req_valid=%b instr_valid=%b fetch_err=%b expected 0 0 0",
                     imem_req_valid, instr_valid, fetch_err);
        end
        reset_n = 1'b1;
    endtask

    // Memory side of one fetch: back-pressure, response delay, then checks
    // the presented instruction. Entered and left just after a falling edge.
    task automatic fetch_one(input int rdy_dly, input int rsp_dly, input logic [31:0] data);
        int guard;
        guard = 0;
        while (imem_req_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (imem_req_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL req_timeout: req_valid=%b expected 1 within 20 cycles", imem_req_valid);
        end
        tests_run++;
        if (imem_req_addr !== exp_pc) begin
            tests_failed++;
            $display("FAIL req_addr: got %h expected %h", imem_req_addr, exp_pc);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            imem_req_ready = 1'b0;
            instr_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
                tests_failed++;
                $display("FAIL req_stable: valid=%b addr=%h expected 1 %h",
                         imem_req_valid, imem_req_addr, exp_pc);
            end
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL req_drop: req_valid=%b expected 0 after accept", imem_req_valid);
        end
        for (int i = 0; i < rsp_dly; i++) begin
            imem_rsp_valid = 1'b0;
            instr_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL wait_idle: instr_valid=%b req_valid=%b expected 0 0",
                         instr_valid, imem_req_valid);
            end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        instr_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        instr_ready    = 1'b0;
        exp_instr      = data;
        tests_run++;
        if (instr_valid !== 1'b1 || Instr !== exp_instr) begin
            tests_failed++;
            $display("FAIL present: instr_valid=%b Instr=%h expected 1 %h", instr_valid, Instr, exp_instr);
        end
        tests_run++;
        if (PC !== exp_pc || instr_count !== exp_count) begin
            tests_failed++;
            $display("FAIL present_pc: PC=%h count=%h expected %h %h", PC, instr_count, exp_pc, exp_count);
        end
    endtask

    // Datapath side of a commit; the model picks the next PC by priority.
    task automatic commit(input logic j, input logic s, input logic [31:0] p4,
                          input logic [31:0] br, input logic [31:0] jt);
        Jump        = j;
        PCSrc       = s;
        PCPlus4     = p4;
        PCBranch    = br;
        PCJump      = jt;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        Jump        = 1'($urandom_range(0, 1));
        PCSrc       = 1'($urandom_range(0, 1));
        PCPlus4     = $urandom;
        PCBranch    = $urandom;
        PCJump      = $urandom;
        if (j)      exp_pc = jt;
        else if (s) exp_pc = br;
        else        exp_pc = p4;
        exp_count = exp_count + 32'd1;
        exp_err   = (exp_pc % 4) != 0;
        tests_run++;
        if (PC !== exp_pc) begin
            tests_failed++;
            $display("FAIL commit_pc: got %h expected %h", PC, exp_pc);
        end
        tests_run++;
        if (instr_count !== exp_count) begin
            tests_failed++;
            $display("FAIL commit_count: got %h expected %h", instr_count, exp_count);
        end
        tests_run++;
        if (instr_valid !== 1'b0 || fetch_err !== exp_err || imem_req_valid !== !exp_err) begin
            tests_failed++;
            $display("FAIL commit_flags: instr_valid=%b fetch_err=%b req_valid=%b expected 0 %b %b",
                     instr_valid, fetch_err, imem_req_valid, exp_err, !exp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_sequential();
        fetch_one(0, 0, 32'h2008_0005);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
        fetch_one(0, 0, 32'h2009_0003);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
        tests_run++;
        if (instr_count !== 32'd2 || PC !== 32'd8) begin
            tests_failed++;
            $display("FAIL seq_total: count=%0d PC=%h expected 2 00000008", instr_count, PC);
        end
    endtask

    task automatic test_priority();
        fetch_one(0, 0, $urandom);
        commit(1'b1, 1'b1, 32'd12, 32'd32, 32'd64);
        fetch_one(0, 0, $urandom);
        commit(1'b1, 1'b0, 32'd68, 32'd0, 32'd8);
        fetch_one(0, 0, $urandom);
        commit(1'b0, 1'b1, 32'd12, 32'd32, 32'd64);
    endtask

    task automatic test_backpressure();
        fetch_one(3, 4, $urandom);
        commit(1'b0, 1'b0, exp_pc + 32'd4, $urandom, $urandom);
    endtask

    task automatic test_stall_stray();
        fetch_one(1, 1, $urandom);
        for (int i = 0; i < 5; i++) begin
            instr_ready    = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            Jump           = 1'($urandom_range(0, 1));
            PCSrc          = 1'($urandom_range(0, 1));
            PCJump         = $urandom;
            @(negedge clk);
            tests_run++;
            if (Instr !== exp_instr || PC !== exp_pc || instr_count !== exp_count || instr_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold: Instr=%h PC=%h count=%h valid=%b expected %h %h %h 1",
                         Instr, PC, instr_count, instr_valid, exp_instr, exp_pc, exp_count);
            end
        end
        imem_rsp_valid = 1'b0;
        commit(1'b0, 1'b0, exp_pc + 32'd4, $urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        realtime t_prev;
        realtime t_now;
        fetch_one(0, 0, $urandom);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
        t_prev = $realtime;
        for (int i = 0; i < 3; i++) begin
            imem_req_ready = 1'b1;
            fetch_one(0, 0, $urandom);
            commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
            t_now = $realtime;
            tests_run++;
            if (t_now - t_prev != 30.0) begin
                tests_failed++;
                $display("FAIL b2b_rate: commit spacing %0t expected 30", t_now - t_prev);
            end
            t_prev = t_now;
        end
    endtask

    task automatic test_random();
        logic        j;
        logic        s;
        for (int i = 0; i < 25; i++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            j = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 1) == 1);
            commit(j, s, exp_pc + 32'd4, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_counter_wrap();
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        @(negedge clk);
        exp_count = 32'hFFFF_FFFF;
        fetch_one(0, 1, $urandom);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
        tests_run++;
        if (instr_count !== 32'h0) begin
            tests_failed++;
            $display("FAIL count_wrap: got %h expected 00000000", instr_count);
        end
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        do_reset();
        fetch_one(0, 0, $urandom);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
    endtask

    task automatic test_misaligned();
        fetch_one(0, 0, $urandom);
        commit(1'b0, 1'b1, exp_pc + 32'd4, 32'h0000_0022, 32'h0);
        for (int i = 0; i < 6; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            instr_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1 || PC !== 32'h22) begin
                tests_failed++;
                $display("FAIL err_sticky: req_valid=%b instr_valid=%b fetch_err=%b PC=%h expected 0 0 1 00000022",
                         imem_req_valid, instr_valid, fetch_err, PC);
            end
        end
        do_reset();
        fetch_one(0, 0, $urandom);
        commit(1'b0, 1'b0, exp_pc + 32'd4, 32'h0, 32'h0);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        PCSrc          = 1'b0;
        Jump           = 1'b0;
        PCPlus4        = 32'h0;
        PCBranch       = 32'h0;
        PCJump         = 32'h0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_priority();
        test_backpressure();
        test_stall_stray();
        test_back_to_back();
        test_random();
        test_counter_wrap();
        test_reset_mid();
        test_misaligned();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
